// File: rtl/datapath_mc_if.sv
// Control/data bundle between the SimpleCPU control unit (master) and datapath_mc (slave).
interface datapath_mc_if #(
    parameter int DATA_W  = 16,
    parameter int AW      = 4,
    parameter int CONST_W = 8
);
    logic [AW-1:0]      RF_W_addr;
    logic               RF_W_wr;
    logic [AW-1:0]      RF_Rp_addr;
    logic               RF_Rp_rd;
    logic [AW-1:0]      RF_Rq_addr;
    logic               RF_Rq_rd;
    logic [1:0]         wb_sel;
    logic               RF_ext;
    logic [2:0]         alu_op;
    logic               flags_we;
    logic [DATA_W-1:0]  DM_Din;
    logic [CONST_W-1:0] Val_cons;
    logic               mul_start;
    logic               mul_busy;
    logic               mul_done;
    logic               wb_collision;
    logic [3:0]         flags;
    logic               RF_Rp_zero;
    logic [DATA_W-1:0]  Rp_data;

    modport master (
        output RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
               wb_sel, RF_ext, alu_op, flags_we, DM_Din, Val_cons, mul_start,
        input  mul_busy, mul_done, wb_collision, flags, RF_Rp_zero, Rp_data
    );

    modport slave (
        input  RF_W_addr, RF_W_wr, RF_Rp_addr, RF_Rp_rd, RF_Rq_addr, RF_Rq_rd,
               wb_sel, RF_ext, alu_op, flags_we, DM_Din, Val_cons, mul_start,
        output mul_busy, mul_done, wb_collision, flags, RF_Rp_zero, Rp_data
    );
endinterface

// File: rtl/datapath_mc.sv
// SimpleCPU datapath: register file, ALU with registered {Z,N,C,V} flags, write-back mux
// and a shift-add multiplier that writes its product back to the register file on its own.
module datapath_mc #(
    parameter int DATA_W   = 16,
    parameter int RF_DEPTH = 16,
    parameter int CONST_W  = 8
) (
    input  logic          clk,
    input  logic          rst,
    datapath_mc_if.slave  bus
);
    localparam int AW = (RF_DEPTH > 1) ? $clog2(RF_DEPTH) : 1;
    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [DATA_W-1:0] rf_q [RF_DEPTH];
    logic [DATA_W-1:0] rp_data, rq_data;
    logic [DATA_W-1:0] alu_res, wb_src, wb_val;
    logic [DATA_W:0]   alu_ext;
    logic              alu_c, alu_v;
    logic [3:0]        flags_q;

    logic [1:0]        mul_state_q, mul_state_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, mul_acc_q, mul_acc_d;
    logic [DATA_W-1:0] mul_acc_step;
    logic [CW-1:0]     mul_cnt_q, mul_cnt_d;
    logic [AW-1:0]     mul_dest_q, mul_dest_d;
    logic              mul_wr;
    logic              wb_collision_q;

    assign rp_data = bus.RF_Rp_rd ? rf_q[bus.RF_Rp_addr] : '0;
    assign rq_data = bus.RF_Rq_rd ? rf_q[bus.RF_Rq_addr] : '0;

    always_comb begin
        alu_ext = '0;
        alu_res = rp_data;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        case (bus.alu_op)
            3'd1: begin
                alu_ext = {1'b0, rp_data} + {1'b0, rq_data};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (rp_data[DATA_W-1] == rq_data[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rp_data[DATA_W-1]);
            end
            3'd2: begin
                // The extra bit of an unsigned subtract is the borrow (A < B).
                alu_ext = {1'b0, rp_data} - {1'b0, rq_data};
                alu_res = alu_ext[DATA_W-1:0];
                alu_c   = alu_ext[DATA_W];
                alu_v   = (rp_data[DATA_W-1] != rq_data[DATA_W-1]) &&
                          (alu_res[DATA_W-1] != rp_data[DATA_W-1]);
            end
            3'd3: alu_res = rp_data & rq_data;
            3'd4: alu_res = rp_data | rq_data;
            3'd5: alu_res = rp_data ^ rq_data;
            3'd6: begin
                alu_res = {rp_data[DATA_W-2:0], 1'b0};
                alu_c   = rp_data[DATA_W-1];
            end
            3'd7: begin
                alu_res = {1'b0, rp_data[DATA_W-1:1]};
                alu_c   = rp_data[0];
            end
            default: alu_res = rp_data;
        endcase
    end

    always_comb begin
        case (bus.wb_sel)
            2'd0:    wb_src = alu_res;
            2'd1:    wb_src = bus.DM_Din;
            2'd2:    wb_src = {{(DATA_W-CONST_W){1'b0}}, bus.Val_cons};
            default: wb_src = {{(DATA_W-CONST_W){bus.Val_cons[CONST_W-1]}}, bus.Val_cons};
        endcase
        wb_val = bus.RF_ext ? (~wb_src + DATA_W'(1)) : wb_src;
    end

    assign mul_acc_step = mul_b_q[0] ? (mul_acc_q + mul_a_q) : mul_acc_q;
    assign mul_wr       = (mul_state_q == ST_RUN) && (mul_cnt_q == CW'(DATA_W - 1));

    always_comb begin
        mul_state_d = mul_state_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        mul_acc_d   = mul_acc_q;
        mul_cnt_d   = mul_cnt_q;
        mul_dest_d  = mul_dest_q;
        case (mul_state_q)
            ST_IDLE: begin
                if (bus.mul_start) begin
                    mul_a_d     = rp_data;
                    mul_b_d     = rq_data;
                    mul_dest_d  = bus.RF_W_addr;
                    mul_acc_d   = '0;
                    mul_cnt_d   = '0;
                    mul_state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                mul_acc_d = mul_acc_step;
                mul_a_d   = mul_a_q << 1;
                mul_b_d   = mul_b_q >> 1;
                mul_cnt_d = mul_cnt_q + CW'(1);
                if (mul_wr) begin
                    mul_state_d = ST_DONE;
                end
            end
            default: mul_state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < RF_DEPTH; i++) begin
                rf_q[i] <= '0;
            end
            flags_q        <= '0;
            mul_state_q    <= ST_IDLE;
            mul_a_q        <= '0;
            mul_b_q        <= '0;
            mul_acc_q      <= '0;
            mul_cnt_q      <= '0;
            mul_dest_q     <= '0;
            wb_collision_q <= 1'b0;
        end else begin
            // Multiplier write-back has priority over the normal write port.
            for (int i = 0; i < RF_DEPTH; i++) begin
                if (mul_wr && (mul_dest_q == AW'(i))) begin
                    rf_q[i] <= mul_acc_step;
                end else if (bus.RF_W_wr && !mul_wr && (bus.RF_W_addr == AW'(i))) begin
                    rf_q[i] <= wb_val;
                end
            end
            if (bus.flags_we) begin
                flags_q <= {(alu_res == '0), alu_res[DATA_W-1], alu_c, alu_v};
            end
            mul_state_q    <= mul_state_d;
            mul_a_q        <= mul_a_d;
            mul_b_q        <= mul_b_d;
            mul_acc_q      <= mul_acc_d;
            mul_cnt_q      <= mul_cnt_d;
            mul_dest_q     <= mul_dest_d;
            wb_collision_q <= mul_wr && bus.RF_W_wr;
        end
    end

    assign bus.Rp_data      = rp_data;
    assign bus.RF_Rp_zero   = (rp_data == '0);
    assign bus.flags        = flags_q;
    assign bus.mul_busy     = (mul_state_q == ST_RUN);
    assign bus.mul_done     = (mul_state_q == ST_DONE);
    assign bus.wb_collision = wb_collision_q;
endmodule

// File: tb/tb_datapath_mc.sv
// Randomised and directed bench for datapath_mc against a cycle-indexed behavioural model.
module tb_datapath_mc;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    datapath_mc_if #(.DATA_W(16), .AW(4), .CONST_W(8)) bus ();

    datapath_mc #(.DATA_W(16), .RF_DEPTH(16), .CONST_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    // Model state: register contents, flags, and the multiply as "started in cycle m_start".
    logic [15:0] m_rf [16];
    logic [3:0]  m_flags;
    bit          m_coll;
    bit          m_active;
    int          m_start;
    logic [15:0] m_prod;
    logic [3:0]  m_dest;
    int          cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    endtask

    task automatic idle_inputs();
        rst            = 1'b0;
        bus.RF_W_addr  = '0;
        bus.RF_W_wr    = 1'b0;
        bus.RF_Rp_addr = '0;
        bus.RF_Rp_rd   = 1'b0;
        bus.RF_Rq_addr = '0;
        bus.RF_Rq_rd   = 1'b0;
        bus.wb_sel     = '0;
        bus.RF_ext     = 1'b0;
        bus.alu_op     = '0;
        bus.flags_we   = 1'b0;
        bus.DM_Din     = '0;
        bus.Val_cons   = '0;
        bus.mul_start  = 1'b0;
    endtask

    task automatic model_step();
        logic [15:0] a, b, r, src, wbv;
        logic c, v;
        int sa, sb, sr;
        longint unsigned ua, ub;
        bit mul_wr;
        a  = bus.RF_Rp_rd ? m_rf[bus.RF_Rp_addr] : 16'h0;
        b  = bus.RF_Rq_rd ? m_rf[bus.RF_Rq_addr] : 16'h0;
        ua = a; ub = b;
        sa = int'($signed(a)); sb = int'($signed(b));
        c = 1'b0; v = 1'b0; r = a;
        case (bus.alu_op)
            3'd1: begin r = 16'(ua + ub); c = (ua + ub) > 65535; sr = sa + sb; v = (sr > 32767) || (sr < -32768); end
            3'd2: begin r = 16'(ua - ub); c = ua < ub;           sr = sa - sb; v = (sr > 32767) || (sr < -32768); end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = a ^ b;
            3'd6: begin r = 16'(ua * 2); c = ua >= 32768; end
            3'd7: begin r = 16'(ua / 2); c = ua[0]; end
            default: r = a;
        endcase
        case (bus.wb_sel)
            2'd0: src = r;
            2'd1: src = bus.DM_Din;
            2'd2: src = 16'(bus.Val_cons);
            default: src = 16'(int'($signed(bus.Val_cons)));
        endcase
        wbv = bus.RF_ext ? 16'(0 - int'(src)) : src;
        if (rst) begin
            for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
            m_flags = 4'h0; m_coll = 1'b0; m_active = 1'b0;
        end else begin
            mul_wr = m_active && (cyc == m_start + 16);
            if (bus.RF_W_wr && !mul_wr) m_rf[bus.RF_W_addr] = wbv;
            if (mul_wr) begin
                m_rf[m_dest] = m_prod;
                $display("mul write-back: R%0d <= %0h (cycle %0d)", m_dest, m_prod, cyc);
            end
            m_coll = mul_wr && bus.RF_W_wr;
            if (bus.flags_we) m_flags = {r == 16'h0, r[15], c, v};
            if (bus.mul_start && !(m_active && cyc <= m_start + 17)) begin
                m_active = 1'b1;
                m_start  = cyc;
                m_prod   = 16'(ua * ub);
                m_dest   = bus.RF_W_addr;
            end
        end
        cyc++;
    endtask

    // One clock cycle: compare DUT outputs with the model mid-cycle, advance model, cross the edge.
    task automatic tick();
        logic [15:0] exp_rp;
        #1;
        if (chk_en) begin
            exp_rp = bus.RF_Rp_rd ? m_rf[bus.RF_Rp_addr] : 16'h0;
            check_eq("rp_data", 32'(bus.Rp_data), 32'(exp_rp));
            check_eq("rp_zero", 32'(bus.RF_Rp_zero), 32'(exp_rp == 16'h0));
            check_eq("flags", 32'(bus.flags), 32'(m_flags));
            check_eq("mul_busy", 32'(bus.mul_busy), 32'(m_active && cyc >= m_start + 1 && cyc <= m_start + 16));
            check_eq("mul_done", 32'(bus.mul_done), 32'(m_active && cyc == m_start + 17));
            check_eq("wb_collision", 32'(bus.wb_collision), 32'(m_coll));
        end
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] addr, input logic [15:0] val);
        idle_inputs();
        bus.RF_W_addr = addr; bus.RF_W_wr = 1'b1; bus.wb_sel = 2'd1; bus.DM_Din = val;
        tick();
    endtask

    task automatic expect_reg(input string tag, input logic [3:0] addr, input logic [15:0] val);
        idle_inputs();
        bus.RF_Rp_addr = addr; bus.RF_Rp_rd = 1'b1;
        #1;
        check_eq(tag, 32'(bus.Rp_data), 32'(val));
        tick();
    endtask

    task automatic const_wr(input logic [1:0] sel, input bit ext, input logic [15:0] exp, input string tag);
        idle_inputs();
        bus.RF_W_addr = 4'd1; bus.RF_W_wr = 1'b1; bus.wb_sel = sel; bus.RF_ext = ext; bus.Val_cons = 8'hFF;
        tick();
        expect_reg(tag, 4'd1, exp);
    endtask

    task automatic run_mul(input logic [3:0] pa, input logic [3:0] pb, input logic [3:0] dest,
                           input int coll_reg, input bit restart, input logic [15:0] exp);
        idle_inputs();
        bus.RF_Rp_addr = pa; bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = pb; bus.RF_Rq_rd = 1'b1;
        bus.RF_W_addr = dest; bus.mul_start = 1'b1;
        tick();
        for (int i = 1; i <= 16; i++) begin
            idle_inputs();
            bus.RF_Rp_addr = dest; bus.RF_Rp_rd = 1'b1;
            #1;
            check_eq("run_busy", 32'(bus.mul_busy), 32'd1);
            if (restart && i == 3) begin
                bus.RF_Rq_addr = pa; bus.RF_Rq_rd = 1'b1; bus.RF_W_addr = dest; bus.mul_start = 1'b1;
            end
            if (coll_reg >= 0 && i == 16) begin
                bus.RF_W_addr = 4'(coll_reg); bus.RF_W_wr = 1'b1; bus.wb_sel = 2'd1; bus.DM_Din = 16'hBEEF;
            end
            tick();
        end
        idle_inputs();
        bus.RF_Rp_addr = dest; bus.RF_Rp_rd = 1'b1;
        #1;
        check_eq("done_pulse", 32'(bus.mul_done), 32'd1);
        check_eq("done_busy", 32'(bus.mul_busy), 32'd0);
        check_eq("mul_result", 32'(bus.Rp_data), 32'(exp));
        check_eq("done_coll", 32'(bus.wb_collision), 32'(coll_reg >= 0));
        tick();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) m_rf[i] = 16'h0;
        m_flags = 4'h0; m_coll = 1'b0; m_active = 1'b0; m_start = 0; m_prod = 16'h0; m_dest = 4'h0;
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b1;
        tick();
        chk_en = 1'b1;

        // Reset state
        idle_inputs();
        #1;
        check_eq("rst_flags", 32'(bus.flags), 32'h0);
        check_eq("rst_busy", 32'(bus.mul_busy), 32'h0);
        tick();
        for (int i = 0; i < 16; i++) begin
            idle_inputs();
            bus.RF_Rp_addr = 4'(i); bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = 4'(i); bus.RF_Rq_rd = 1'b1;
            bus.alu_op = 3'd1; bus.flags_we = 1'b1;
            #1;
            check_eq("rst_rf", 32'(bus.Rp_data), 32'h0);
            check_eq("rst_zero", 32'(bus.RF_Rp_zero), 32'h1);
            tick();
        end

        // Constant loads
        const_wr(2'd3, 1'b0, 16'hFFFF, "const_sext");
        const_wr(2'd2, 1'b0, 16'h00FF, "const_zext");
        const_wr(2'd2, 1'b1, 16'hFF01, "const_neg");

        // ALU add overflow, then subtract borrow
        load(4'd1, 16'h7FFF);
        load(4'd2, 16'h0001);
        idle_inputs();
        bus.RF_Rp_addr = 4'd1; bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = 4'd2; bus.RF_Rq_rd = 1'b1;
        bus.alu_op = 3'd1; bus.flags_we = 1'b1; bus.RF_W_addr = 4'd3; bus.RF_W_wr = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_eq("add_flags", 32'(bus.flags), 32'b0101);
        tick();
        expect_reg("add_result", 4'd3, 16'h8000);
        idle_inputs();
        bus.RF_Rp_addr = 4'd2; bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = 4'd1; bus.RF_Rq_rd = 1'b1;
        bus.alu_op = 3'd2; bus.flags_we = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_eq("sub_flags", 32'(bus.flags), 32'b0110);
        tick();

        // Multiplier, wrap, collision with ignored restart
        load(4'd4, 16'd300);
        load(4'd5, 16'd7);
        run_mul(4'd4, 4'd5, 4'd6, -1, 1'b0, 16'd2100);
        load(4'd4, 16'h0100);
        load(4'd5, 16'h0100);
        run_mul(4'd4, 4'd5, 4'd6, -1, 1'b0, 16'h0000);
        load(4'd4, 16'd300);
        load(4'd5, 16'd7);
        load(4'd7, 16'h1234);
        run_mul(4'd4, 4'd5, 4'd6, 7, 1'b1, 16'd2100);
        expect_reg("coll_r7", 4'd7, 16'h1234);

        // Reset during RUN cycle 5 aborts the multiply
        load(4'd10, 16'd77);
        load(4'd8, 16'd5);
        load(4'd9, 16'd9);
        idle_inputs();
        bus.RF_Rp_addr = 4'd8; bus.RF_Rp_rd = 1'b1; bus.RF_Rq_addr = 4'd9; bus.RF_Rq_rd = 1'b1;
        bus.RF_W_addr = 4'd10; bus.mul_start = 1'b1;
        tick();
        for (int i = 1; i <= 4; i++) begin
            idle_inputs();
            tick();
        end
        idle_inputs();
        rst = 1'b1;
        tick();
        idle_inputs();
        #1;
        check_eq("abort_busy", 32'(bus.mul_busy), 32'h0);
        tick();
        expect_reg("abort_dest", 4'd10, 16'h0);
        for (int i = 0; i < 20; i++) begin
            idle_inputs();
            #1;
            check_eq("abort_nodone", 32'(bus.mul_done), 32'h0);
            tick();
        end

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            idle_inputs();
            rst            = ($urandom_range(0, 399) == 0);
            bus.RF_W_addr  = 4'($urandom_range(0, 15));
            bus.RF_W_wr    = 1'($urandom_range(0, 1));
            bus.RF_Rp_addr = 4'($urandom_range(0, 15));
            bus.RF_Rp_rd   = ($urandom_range(0, 7) != 0);
            bus.RF_Rq_addr = 4'($urandom_range(0, 15));
            bus.RF_Rq_rd   = ($urandom_range(0, 7) != 0);
            bus.wb_sel     = 2'($urandom_range(0, 3));
            bus.RF_ext     = ($urandom_range(0, 3) == 0);
            bus.alu_op     = 3'($urandom_range(0, 7));
            bus.flags_we   = 1'($urandom_range(0, 1));
            bus.DM_Din     = 16'($urandom);
            bus.Val_cons   = 8'($urandom);
            bus.mul_start  = ($urandom_range(0, 7) == 0);
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/datapath_mc.md
Name: datapath_mc

Overview:
Parametrised next-generation datapath for the SimpleCPU family. It contains an internal register file, a multi-op ALU, a write-back source mux with constant load and two's-complement negate, and registered status flags. It also adds a multi-cycle shift-add multiplier with a start/busy/done handshake that writes its result back to the register file autonomously. The control unit drives it directly, and data memory sits on DM_Din and Rp_data.

Parameters:
DATA_W, 16, datapath and register width (>=4)
RF_DEPTH, 16, number of registers; AW = clog2(RF_DEPTH)
CONST_W, 8, width of immediate constant (< DATA_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
RF_W_addr  in  AW  write-port register address
RF_W_wr  in  1  write enable for normal write-back
RF_Rp_addr  in  AW  read port P address
RF_Rp_rd  in  1  read port P enable
RF_Rq_addr  in  AW  read port Q address
RF_Rq_rd  in  1  read port Q enable
wb_sel  in  2  write-back source: 0 ALU, 1 DM_Din, 2 const zero-ext, 3 const sign-ext
RF_ext  in  1  negate selected write-back value (two's complement)
alu_op  in  3  0 pass A, 1 A+B, 2 A-B, 3 A&B, 4 A|B, 5 A^B, 6 A<<1, 7 A>>1 (logical)
flags_we  in  1  update flag register from the ALU this cycle
DM_Din  in  DATA_W  data memory read data
Val_cons  in  CONST_W  immediate constant
mul_start  in  1  request multiply Rp_data*Rq_data into RF_W_addr
mul_busy  out  1  multiplier running
mul_done  out  1  one-cycle pulse after the multiply result is written
wb_collision  out  1  one-cycle pulse: normal write dropped due to multiplier write-back
flags  out  4  {Z,N,C,V} registered
RF_Rp_zero  out  1  combinational: Rp_data == 0
Rp_data  out  DATA_W  read port P data (memory write data / address)

Behaviour:
- Reset: all registers, flags, mul_busy, mul_done, wb_collision and the multiplier state go to 0. Reset mid-multiply aborts it with no write-back.
- Reads are combinational. Rp_data/Rq_data = reg[addr] when the port's rd enable is 1, else 0. There is no write-to-read bypass: a written value is readable the cycle after the write edge.
- Write-back value: src chosen by wb_sel. If RF_ext = 1, the value is (~src)+1 truncated to DATA_W. It is written at the rising edge when RF_W_wr = 1.
- ALU: arithmetic is performed at DATA_W+1 bits.
  - C = carry-out for add; for sub, C = borrow (A<B unsigned); for shifts, C = the bit shifted out; for logic/pass ops, C = 0.
  - V = signed overflow for add/sub, else 0.
  - N = MSB of result; Z = result == 0.
  - Flags load at the edge when flags_we = 1, independent of RF_W_wr.
- Multiplier FSM, states IDLE, RUN, DONE:
  - IDLE: mul_start = 1 latches A = Rp_data, B = Rq_data and dest = RF_W_addr, clears the accumulator and sets count = 0, then goes to RUN. A normal write in the same cycle still happens.
  - RUN (mul_busy = 1, exactly DATA_W cycles): each cycle, if B[0] then acc += A; then A <<= 1, B >>= 1.
  - At the edge ending the last RUN cycle, reg[dest] <= acc[DATA_W-1:0] (low half, wraps modulo 2^DATA_W), then the FSM goes to DONE.
  - DONE: mul_done = 1 and mul_busy = 0 for one cycle, then IDLE. mul_start in DONE is ignored.
  - mul_start while busy is ignored; the operands are not re-latched.
  - Latency is start edge to result write = DATA_W cycles. The result is readable during the mul_done cycle.
- Write collision: if RF_W_wr = 1 on the multiplier write-back edge, the multiplier write wins and the normal write is dropped. wb_collision is high the following cycle, coincident with mul_done. Normal writes during other RUN cycles proceed, including to dest; dest is overwritten later by the multiplier.
- flags are not affected by the multiplier.

Test Plan:
1. Reset, then read R0..R15 with both ports -> all 0. RF_Rp_zero = 1, flags = 0000.
2. Load const Val_cons = 8'hFF with wb_sel = 3 into R1 -> R1 = 16'hFFFF. With wb_sel = 2 -> 16'h00FF. With wb_sel = 2 and RF_ext = 1 -> 16'hFF01.
3. R1 = 16'h7FFF, R2 = 1, alu_op = 1, flags_we = 1, write R3 -> R3 = 16'h8000, flags {Z,N,C,V} = 0101. Then alu_op = 2 with R2 - R1 -> C = 1 (borrow).
4. R4 = 300, R5 = 7, mul_start with dest R6 -> mul_busy high for 16 cycles, R6 = 2100 in the mul_done cycle. R4 = R5 = 16'h0100 gives R6 = 0 (wrap).
5. Assert RF_W_wr to R7 on the multiplier write-back edge -> R6 gets the product, R7 is unchanged, wb_collision = 1 together with mul_done. mul_start during RUN -> ignored, single mul_done.
6. Assert rst at RUN cycle 5 -> mul_busy = 0 next cycle, dest register = 0, no mul_done ever pulses.
